// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the two requester ports and the shared RAM port
// used by ram_arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester commands
//   ack0/ack1  : one-cycle completion pulse per requester
//   rdata      : read result, valid while the matching ack is high
//   busy       : arbiter is mid-transaction
//   ram_address/ram_data/ram_wren : single-port RAM command
//   ram_q      : RAM read data, one cycle after the address
// Modports: slave = arbiter view, master = requesters + RAM view.
interface ram_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [4:0]  addr0;
  logic [4:0]  addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rdata;
  logic        busy;
  logic [4:0]  ram_address;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output ack0, ack1, rdata, busy, ram_address, ram_data, ram_wren
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  ack0, ack1, rdata, busy, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between requester 0 (control unit)
// and requester 1 (loader/debug port). Each transaction walks
// IDLE -> ISSUE -> WAIT -> DONE, so an accepted request is acknowledged three
// cycles later and one transaction completes every four cycles.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : ram_arbiter_if.slave (requester commands, acks, rdata, busy,
//           RAM address/data/write-enable and RAM read data)
// Build option: define RAM_ARB_ROUND_ROBIN_EN to alternate the winner of
// simultaneous requests; otherwise requester 0 always wins a tie.
module ram_arbiter (
  input  logic           clock,
  input  logic           reset,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        id_q, id_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        win;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      win = ~last_q;
    end else begin
      win = bus.req1;
    end
  end
`else
  // Requester 0 has fixed priority.
  always_comb begin
    win = ~bus.req0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ISSUE;
          id_d    = win;
          we_d    = win ? bus.we1    : bus.we0;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d  = win;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        // RAM data for the address issued last cycle is on ram_q now.
        if (!we_q) begin
          rdata_d = bus.ram_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The latched command doubles as the RAM address/data, so these hold
  // their last value outside ISSUE; only the write strobe is gated.
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = wdata_q;
  assign bus.ram_wren    = (state_q == ISSUE) && we_q;
  assign bus.ack0        = (state_q == DONE) && !id_q;
  assign bus.ack1        = (state_q == DONE) && id_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a cycle-level
// transaction model (acceptance time + memory contents) checked every cycle,
// and literal expectations for the individual scenarios.
module tb_ram_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Bench-side RAM: registered read, write on ram_wren.
  logic [15:0] ram [32];
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
  end
  always @(posedge clock) begin
    if (bus.ram_wren) ram[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= ram[bus.ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  // A request accepted in IDLE cycle t_acc gives: RAM strobe at t_acc+1,
  // read data captured at end of t_acc+2, ack at t_acc+3, busy over
  // t_acc+1..t_acc+3; the next acceptance can happen at t_acc+4.
  logic [15:0] mmem [32];
  int          t_acc = -1000;
  bit          m_ok  = 1'b0;
  logic        m_we, m_id, m_ptr;
  logic [4:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;

  initial begin
    for (int i = 0; i < 32; i++) mmem[i] = '0;
  end

  always @(negedge clock) begin
    int   k;
    logic w;
    k = cyc - t_acc;
    if (m_ok) begin
      chk("busy",        32'(bus.busy),        32'(k >= 1 && k <= 3));
      chk("ack0",        32'(bus.ack0),        32'(k == 3 && m_id == 1'b0));
      chk("ack1",        32'(bus.ack1),        32'(k == 3 && m_id == 1'b1));
      chk("ram_wren",    32'(bus.ram_wren),    32'(k == 1 && m_we));
      chk("ram_address", 32'(bus.ram_address), 32'(m_addr));
      chk("ram_data",    32'(bus.ram_data),    32'(m_wdata));
      chk("rdata",       32'(bus.rdata),       32'(m_rdata));
    end
    if (k == 1 && m_we) mmem[m_addr] = m_wdata;
    if (reset) begin
      t_acc   = -1000;
      m_we    = 1'b0;
      m_id    = 1'b0;
      m_ptr   = 1'b1;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
      m_ok    = 1'b1;
    end else begin
      if (k == 2 && !m_we) m_rdata = mmem[m_addr];
      if ((k < 1 || k > 3) && (bus.req0 || bus.req1)) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (bus.req0 && bus.req1) w = !m_ptr;
        else                      w = bus.req1;
        m_ptr = w;
`else
        w = bus.req0 ? 1'b0 : 1'b1;
`endif
        t_acc   = cyc;
        m_id    = w;
        m_we    = w ? bus.we1    : bus.we0;
        m_addr  = w ? bus.addr1  : bus.addr0;
        m_wdata = w ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit id, input bit r, input bit we, input logic [4:0] a,
                       input logic [15:0] d);
    if (id == 1'b0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Issue one transaction from an IDLE cycle; returns ack latency, number
  // of strobed cycles, strobed address and rdata seen with the ack.
  task automatic xact(input bit id, input bit we, input logic [4:0] a, input logic [15:0] d,
                      output int lat, output int nwr, output logic [4:0] wa,
                      output logic [15:0] rd);
    bit got;
    drive(id, 1'b1, we, a, d);
    lat = 0; nwr = 0; wa = '0; rd = '0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus.ram_wren) begin
        nwr++;
        wa = bus.ram_address;
      end
      if ((id == 1'b0 && bus.ack0) || (id == 1'b1 && bus.ack1)) begin
        rd  = bus.rdata;
        got = 1'b1;
        break;
      end
    end
    if (!got) lat = -1;
    drive(id, 1'b0, 1'b0, a, d);
    tick();
  endtask

  initial begin
    int          lat, nwr, c0, a0, a1, nack;
    logic [4:0]  wa;
    logic [15:0] rd;
    int          ack_t [8];
    logic        ack_id [8];

    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_ack",   32'({bus.ack0, bus.ack1}), 32'd0);
    chk("rst_wren",  32'(bus.ram_wren),    32'd0);
    chk("rst_addr",  32'(bus.ram_address), 32'd0);
    chk("rst_data",  32'(bus.ram_data),    32'd0);
    chk("rst_rdata", 32'(bus.rdata),       32'd0);
    reset = 1'b0;
    tick();

    // Write BEEF to 3, then read it back.
    xact(1'b0, 1'b1, 5'd3, 16'hBEEF, lat, nwr, wa, rd);
    chk("wr_lat",  32'(lat), 32'd3);
    chk("wr_nwr",  32'(nwr), 32'd1);
    chk("wr_addr", 32'(wa),  32'd3);
    xact(1'b0, 1'b0, 5'd3, 16'h0000, lat, nwr, wa, rd);
    chk("rd_lat",  32'(lat), 32'd3);
    chk("rd_nwr",  32'(nwr), 32'd0);
    chk("rd_data", 32'(rd),  32'hBEEF);

    // A write leaves the previous read result in rdata.
    xact(1'b1, 1'b1, 5'd7, 16'h1234, lat, nwr, wa, rd);
    chk("wr1_lat", 32'(lat), 32'd3);
    xact(1'b1, 1'b0, 5'd7, 16'h0000, lat, nwr, wa, rd);
    chk("rd1_data", 32'(rd), 32'h1234);
    xact(1'b0, 1'b1, 5'd8, 16'h5555, lat, nwr, wa, rd);
    chk("wr_keeps_rdata", 32'(rd), 32'h1234);

    // Late request: req1 rises during the ISSUE cycle of a req0 read.
    // Times are counted from the IDLE cycle carrying req0.
    c0 = cyc; a0 = -1; a1 = -1;
    drive(1'b0, 1'b1, 1'b0, 5'd3, 16'h0000);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd7, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack0 && a0 < 0) begin
        a0 = cyc - c0;
        drive(1'b0, 1'b0, 1'b0, 5'd3, 16'h0000);
      end
      if (bus.ack1) begin
        a1 = cyc - c0;
        drive(1'b1, 1'b0, 1'b0, 5'd7, 16'h0000);
        break;
      end
    end
    chk("late_ack0", 32'(a0), 32'd3);
    chk("late_ack1", 32'(a1), 32'd7);
    chk("late_rd1",  32'(bus.rdata), 32'h1234);
    tick();

    // Reset during WAIT of a write abandons it without an ack.
    drive(1'b0, 1'b1, 1'b1, 5'd9, 16'hAAAA);
    tick();                      // ISSUE
    tick();                      // WAIT
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd9, 16'h0000);
    tick();
    chk("rstw_busy", 32'(bus.busy),     32'd0);
    chk("rstw_wren", 32'(bus.ram_wren), 32'd0);
    chk("rstw_ack",  32'({bus.ack0, bus.ack1}), 32'd0);
    reset = 1'b0;
    tick();
    xact(1'b0, 1'b0, 5'd9, 16'h0000, lat, nwr, wa, rd);
    chk("post_rst_lat",  32'(lat), 32'd3);
    chk("post_rst_data", 32'(rd),  32'hAAAA);

    // Both requesters held high from reset.
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd1, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 16'h0000);
    tick();
    reset = 1'b0;
    c0 = cyc;
    nack = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if ((bus.ack0 || bus.ack1) && nack < 8) begin
        ack_t[nack]  = cyc - c0;
        ack_id[nack] = bus.ack1;
        nack++;
      end
    end
    chk("held_nack", 32'(nack), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("held_time", 32'(ack_t[i]), 32'(3 + 4 * i));
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk("held_id_rr", 32'(ack_id[i]), 32'(i % 2));
`else
      chk("held_id_fixed", 32'(ack_id[i]), 32'd0);
`endif
    end
    // Drop req0 on its next ack; req1 must then be served four cycles later.
    a0 = -1; a1 = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.ack0) begin
        a0 = cyc;
        drive(1'b0, 1'b0, 1'b0, 5'd1, 16'h0000);
        break;
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.ack1) begin
        a1 = cyc;
        drive(1'b1, 1'b0, 1'b0, 5'd2, 16'h0000);
        break;
      end
    end
    chk("drop_seen_ack0", 32'(a0 >= 0), 32'd1);
    chk("drop_ack1_gap",  32'(a1 - a0), 32'd4);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
